// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer, the PLL wrapper pins and the core reset tree.
// master = sequencer side, slave = PLL wrapper / reset tree side.
interface pll_lock_sequencer_if;
  logic       pll_locked;
  logic       restart_req;
  logic       pll_rst;
  logic       domain_rst;
  logic       clocks_ready;
  logic       lock_lost;
  logic       fail;
  logic [1:0] retry_count;
  logic [2:0] state;
  logic [7:0] loss_count;

  modport master (
    input  pll_locked, restart_req,
    output pll_rst, domain_rst, clocks_ready, lock_lost, fail,
           retry_count, state, loss_count
  );

  modport slave (
    output pll_locked, restart_req,
    input  pll_rst, domain_rst, clocks_ready, lock_lost, fail,
           retry_count, state, loss_count
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor: pulses pll_rst, qualifies synchronized lock, gates domain reset, bounded retries.
// Latency: all outputs registered; lock seen SYNC_STAGES cycles after pll_locked. No backpressure.
// Optional PLLSEQ_LOSS_COUNTER_EN enables the saturating lock-loss counter on loss_count.
module pll_lock_sequencer #(
  parameter int RST_CYCLES          = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                 refclk,
  input  logic                 rst,
  pll_lock_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_READY     = 3'd3,
    S_FAILED    = 3'd4
  } state_t;

  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [1:0]       MAX_R       = 2'(MAX_RETRIES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [1:0]             retry_q;
  logic                   pll_rst_q;
  logic                   domain_rst_q;
  logic                   ready_q;
  logic                   lost_q;
  logic                   fail_q;
`ifdef PLLSEQ_LOSS_COUNTER_EN
  logic [7:0]             loss_q;
`endif

  always_ff @(posedge refclk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Every transition clears cnt_q, so each terminal compare also bounds the counter.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= S_RESET_PLL;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_rst_q    <= 1'b1;
      domain_rst_q <= 1'b1;
      ready_q      <= 1'b0;
      lost_q       <= 1'b0;
      fail_q       <= 1'b0;
`ifdef PLLSEQ_LOSS_COUNTER_EN
      loss_q       <= '0;
`endif
    end else if (bus.restart_req) begin
      state_q      <= S_RESET_PLL;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_rst_q    <= 1'b1;
      domain_rst_q <= 1'b1;
      ready_q      <= 1'b0;
      lost_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      lost_q <= 1'b0;
      case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_q   <= S_WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_q <= S_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            if (retry_q < MAX_R) begin
              state_q <= S_RESET_PLL;
              retry_q <= retry_q + 1'b1;
            end else begin
              state_q <= S_FAILED;
              fail_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STABLE: begin
          // A dropout here is treated as a glitch: fresh timeout, retry budget untouched.
          if (!locked_s) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q      <= S_READY;
            cnt_q        <= '0;
            domain_rst_q <= 1'b0;
            ready_q      <= 1'b1;
            retry_q      <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_READY: begin
          if (!locked_s) begin
            state_q      <= S_RESET_PLL;
            cnt_q        <= '0;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= 1'b1;
            ready_q      <= 1'b0;
            lost_q       <= 1'b1;
`ifdef PLLSEQ_LOSS_COUNTER_EN
            if (loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
`endif
          end
        end
        S_FAILED: begin
          pll_rst_q    <= 1'b1;
          domain_rst_q <= 1'b1;
          ready_q      <= 1'b0;
          fail_q       <= 1'b1;
        end
        default: begin
          state_q      <= S_RESET_PLL;
          cnt_q        <= '0;
          pll_rst_q    <= 1'b1;
          domain_rst_q <= 1'b1;
          ready_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.domain_rst   = domain_rst_q;
  assign bus.clocks_ready = ready_q;
  assign bus.lock_lost    = lost_q;
  assign bus.fail         = fail_q;
  assign bus.retry_count  = retry_q;
  assign bus.state        = state_q;
`ifdef PLLSEQ_LOSS_COUNTER_EN
  assign bus.loss_count   = loss_q;
`else
  assign bus.loss_count   = '0;
`endif

endmodule
